// File: rtl/safe_sequencer_if.sv
// safe_sequencer_if
//   Decoded keypad event channel between the key decoder and the safe
//   sequencer. One event per cycle at most.
//   key_valid : one-cycle strobe, key_code is meaningful in that cycle
//   key_code  : 0-9 digit, 10 star (clear/alt), 11 sharp (enter), 12-15 unused
//   master    : drives the event (decoder / testbench)
//   slave     : consumes the event (safe_sequencer)
interface safe_sequencer_if;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (output key_valid, output key_code);
    modport slave  (input  key_valid, input  key_code);
endinterface

// File: rtl/safe_sequencer.sv
// safe_sequencer
//   Controller FSM for the keypad safe. Collects a PW_LEN-digit entry,
//   checks it against the stored password, and sequences open, relock,
//   password change and failed-attempt lockout. All outputs are registered.
//
//   Optional feature macro: AUTO_RELOCK_EN
//     defined   : OPEN returns to IDLE after RELOCK_CYCLES cycles without key_valid
//     undefined : OPEN is left only by '#', initialize or reset
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous active-high; default password (all zeros), IDLE
//   key_if       : keypad event channel (slave modport: key_valid, key_code)
//   initialize   : synchronous level; same effect as reset
//   password_led : bit i set once digit i of the current buffer is entered
//   state        : 0 IDLE, 1 ENTRY, 2 CHECK, 3 OPEN, 4 SET, 5 LOCKOUT
//   unlocked     : high while in OPEN or SET
//   alarm        : high while in LOCKOUT
//   tries_left   : MAX_TRIES minus the current consecutive fail count
module safe_sequencer #(
    parameter int unsigned PW_LEN        = 6,
    parameter int unsigned MAX_TRIES     = 3,
    parameter int unsigned LOCK_CYCLES   = 1000,
    parameter int unsigned RELOCK_CYCLES = 5000
) (
    input  logic                clk,
    input  logic                reset,
    safe_sequencer_if.slave     key_if,
    input  logic                initialize,
    output logic [PW_LEN-1:0]   password_led,
    output logic [2:0]          state,
    output logic                unlocked,
    output logic                alarm,
    output logic [3:0]          tries_left
);

    if (PW_LEN < 1 || PW_LEN > 8) begin : g_bad_pw_len
        $error("safe_sequencer: PW_LEN must be 1..8");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
        $error("safe_sequencer: MAX_TRIES must be 1..15");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
        $error("safe_sequencer: LOCK_CYCLES must be >= 1");
    end
    if (RELOCK_CYCLES < 1) begin : g_bad_relock
        $error("safe_sequencer: RELOCK_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_SET     = 3'd4,
        S_LOCKOUT = 3'd5
    } state_e;

    localparam int unsigned CW         = $clog2(PW_LEN + 1);
    localparam int unsigned LW         = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] FULL     = CW'(PW_LEN);
    localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);

    state_e                  state_q;
    logic [4*PW_LEN-1:0]     buf_q;
    logic [4*PW_LEN-1:0]     pw_q;
    logic [CW-1:0]           count_q;
    logic [PW_LEN-1:0]       led_q;
    logic [3:0]              tries_q;
    logic [LW-1:0]           lock_q;
    logic                    unlocked_q;
    logic                    alarm_q;
`ifdef AUTO_RELOCK_EN
    localparam int unsigned RW = $clog2(RELOCK_CYCLES + 1);
    logic [RW-1:0]           relock_q;
`endif

    logic key_digit, key_star, key_sharp, match;
    logic [4*PW_LEN-1:0]     buf_wr_d;
    logic [PW_LEN-1:0]       led_wr_d;

    assign key_digit = key_if.key_valid && (key_if.key_code <= 4'd9);
    assign key_star  = key_if.key_valid && (key_if.key_code == 4'd10);
    assign key_sharp = key_if.key_valid && (key_if.key_code == 4'd11);
    assign match     = (count_q == FULL) && (buf_q == pw_q);

    // Buffer/LED image with the current key written at slot count_q;
    // unchanged once the buffer is full.
    always_comb begin
        buf_wr_d = buf_q;
        led_wr_d = led_q;
        for (int unsigned i = 0; i < PW_LEN; i++) begin
            if (count_q == CW'(i)) begin
                buf_wr_d[4*i +: 4] = key_if.key_code;
                led_wr_d[i]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || initialize) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            pw_q       <= '0;
            count_q    <= '0;
            led_q      <= '0;
            tries_q    <= TRIES_INIT;
            lock_q     <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
`ifdef AUTO_RELOCK_EN
            relock_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_digit) begin
                        buf_q   <= buf_wr_d;
                        led_q   <= led_wr_d;
                        count_q <= count_q + 1'b1;
                        state_q <= S_ENTRY;
                    end
                end

                S_ENTRY: begin
                    if (key_digit) begin
                        if (count_q != FULL) begin
                            buf_q   <= buf_wr_d;
                            led_q   <= led_wr_d;
                            count_q <= count_q + 1'b1;
                        end
                    end else if (key_star) begin
                        buf_q   <= '0;
                        led_q   <= '0;
                        count_q <= '0;
                        state_q <= S_IDLE;
                    end else if (key_sharp) begin
                        state_q <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    buf_q   <= '0;
                    led_q   <= '0;
                    count_q <= '0;
                    if (match) begin
                        tries_q    <= TRIES_INIT;
                        unlocked_q <= 1'b1;
                        state_q    <= S_OPEN;
`ifdef AUTO_RELOCK_EN
                        relock_q   <= RW'(RELOCK_CYCLES - 1);
`endif
                    end else if (tries_q <= 4'd1) begin
                        tries_q <= '0;
                        alarm_q <= 1'b1;
                        // Loaded one short: the exit happens on the edge
                        // that sees zero, giving exactly LOCK_CYCLES cycles.
                        lock_q  <= LW'(LOCK_CYCLES - 1);
                        state_q <= S_LOCKOUT;
                    end else begin
                        tries_q <= tries_q - 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_LOCKOUT: begin
                    if (lock_q == '0) begin
                        alarm_q <= 1'b0;
                        tries_q <= TRIES_INIT;
                        state_q <= S_IDLE;
                    end else begin
                        lock_q <= lock_q - 1'b1;
                    end
                end

                S_OPEN: begin
                    if (key_sharp) begin
                        unlocked_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (key_star) begin
                        buf_q   <= '0;
                        led_q   <= '0;
                        count_q <= '0;
                        state_q <= S_SET;
                    end
`ifdef AUTO_RELOCK_EN
                    else if (key_if.key_valid) begin
                        relock_q <= RW'(RELOCK_CYCLES - 1);
                    end else if (relock_q == '0) begin
                        unlocked_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        relock_q <= relock_q - 1'b1;
                    end
`endif
                end

                S_SET: begin
                    if (key_digit) begin
                        if (count_q != FULL) begin
                            buf_q   <= buf_wr_d;
                            led_q   <= led_wr_d;
                            count_q <= count_q + 1'b1;
                        end
                    end else if (key_sharp || key_star) begin
                        if (key_sharp && count_q == FULL) begin
                            pw_q <= buf_q;
                        end
                        buf_q   <= '0;
                        led_q   <= '0;
                        count_q <= '0;
                        state_q <= S_OPEN;
`ifdef AUTO_RELOCK_EN
                        relock_q <= RW'(RELOCK_CYCLES - 1);
`endif
                    end
                end

                default: begin
                    buf_q      <= '0;
                    led_q      <= '0;
                    count_q    <= '0;
                    unlocked_q <= 1'b0;
                    alarm_q    <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign password_led = led_q;
    assign state        = state_q;
    assign unlocked     = unlocked_q;
    assign alarm        = alarm_q;
    assign tries_left   = tries_q;

endmodule
